// File: rtl/riscv_icache_pkg.sv
// Shared definitions for the instruction-cache miss controller and its tag/data arrays.
package riscv_icache_pkg;

    typedef enum logic [1:0] {
        S_LOOKUP,
        S_REFILL,
        S_TAG
    } icache_state_e;

    localparam int unsigned ICACHE_OFFSET = 6;
    localparam int unsigned ICACHE_BEATS  = 4;

endpackage

// File: rtl/icache_ctrl_i.sv
// Instruction-cache miss controller: refills the addressed block and, for straddling
// instructions, the following block, stalling fetch until both are resident.
module icache_ctrl_i
    import riscv_icache_pkg::*;
#(
    parameter int unsigned ADDR   = 27,
    parameter int unsigned IDX    = 12,
    parameter int unsigned TAG    = 9,
    parameter int unsigned OFFSET = ICACHE_OFFSET,
    parameter int unsigned BEATS  = ICACHE_BEATS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic [ADDR-1:0]          cpu_addr,
    input  logic                     missalign,
    input  logic                     hit,
    input  logic                     hit_missalign,
    output logic                     stall,
    output logic                     mem_req,
    output logic [ADDR-OFFSET-1:0]   mem_addr,
    input  logic                     mem_rvalid,
    output logic                     dwr_en,
    output logic [$clog2(BEATS)-1:0] dwr_beat,
    output logic                     dwr_align,
    output logic                     replace_tag,
    output logic                     valid_in,
    output logic                     replace_tag_align,
    output logic                     valid_in_align
);

    localparam int unsigned BW = $clog2(BEATS);
    localparam int unsigned BA = ADDR - OFFSET;

    if (TAG + IDX + OFFSET != ADDR) begin : g_bad_split
        $error("icache_ctrl_i: TAG+IDX+OFFSET must equal ADDR");
    end
    if (BEATS < 2 || (1 << BW) != BEATS) begin : g_bad_beats
        $error("icache_ctrl_i: BEATS must be a power of two >= 2");
    end

    icache_state_e state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          align_q, align_d;
    logic [BA-1:0] addr_q, addr_d;

    // Byte offset within the block is irrelevant to block-level refills.
    logic unused_offset;
    assign unused_offset = ^cpu_addr[OFFSET-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOOKUP;
            cnt_q   <= '0;
            align_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            align_q <= align_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        align_d           = align_q;
        addr_d            = addr_q;
        mem_req           = 1'b0;
        dwr_en            = 1'b0;
        dwr_beat          = '0;
        dwr_align         = 1'b0;
        replace_tag       = 1'b0;
        valid_in          = 1'b0;
        replace_tag_align = 1'b0;
        valid_in_align    = 1'b0;

        case (state_q)
            S_LOOKUP: begin
                // Primary miss first; a double miss resolves as two back-to-back refills.
                if (cpu_req && !hit) begin
                    addr_d  = cpu_addr[ADDR-1:OFFSET];
                    align_d = 1'b0;
                    state_d = S_REFILL;
                end else if (cpu_req && missalign && !hit_missalign) begin
                    addr_d  = cpu_addr[ADDR-1:OFFSET] + BA'(1);
                    align_d = 1'b1;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req = 1'b1;
                if (mem_rvalid) begin
                    dwr_en    = 1'b1;
                    dwr_beat  = cnt_q;
                    dwr_align = align_q;
                    if (cnt_q == BW'(BEATS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_TAG;
                    end else begin
                        cnt_d = cnt_q + BW'(1);
                    end
                end
            end
            S_TAG: begin
                replace_tag       = !align_q;
                valid_in          = !align_q;
                replace_tag_align = align_q;
                valid_in_align    = align_q;
                state_d           = S_LOOKUP;
            end
            default: state_d = S_LOOKUP;
        endcase
    end

    assign stall    = cpu_req & ((state_q != S_LOOKUP) | !hit | (missalign & !hit_missalign));
    assign mem_addr = addr_q;

endmodule

// File: tb/tb_icache_ctrl_i.sv
// Self-checking bench for icache_ctrl_i with a behavioural tag-array/DRAM model and
// scoreboards for data-beat and tag writes.
module tb_icache_ctrl_i;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [26:0] cpu_addr = '0;
    logic        missalign = 1'b0;
    logic        hit = 1'b0;
    logic        hit_missalign = 1'b0;
    logic        stall;
    logic        mem_req;
    logic [20:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic        dwr_en;
    logic [1:0]  dwr_beat;
    logic        dwr_align;
    logic        replace_tag;
    logic        valid_in;
    logic        replace_tag_align;
    logic        valid_in_align;

    icache_ctrl_i dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_req           (cpu_req),
        .cpu_addr          (cpu_addr),
        .missalign         (missalign),
        .hit               (hit),
        .hit_missalign     (hit_missalign),
        .stall             (stall),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_rvalid        (mem_rvalid),
        .dwr_en            (dwr_en),
        .dwr_beat          (dwr_beat),
        .dwr_align         (dwr_align),
        .replace_tag       (replace_tag),
        .valid_in          (valid_in),
        .replace_tag_align (replace_tag_align),
        .valid_in_align    (valid_in_align)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct packed {
        logic [1:0] beat;
        logic       align;
    } beat_t;

    typedef struct packed {
        logic        align;
        logic [20:0] blk;
    } tagw_t;

    beat_t beat_q[$];
    tagw_t tag_q[$];
    bit    res[logic [20:0]];
    beat_t mon_b;
    tagw_t mon_t;

    task automatic upd_hits();
        logic [20:0] blk;
        blk           = cpu_addr[26:6];
        hit           = res.exists(blk);
        hit_missalign = res.exists(blk + 21'd1);
    endtask

    task automatic expect_refill(input logic align, input logic [20:0] blk);
        for (int i = 0; i < 4; i++) beat_q.push_back('{beat: 2'(i), align: align});
        tag_q.push_back('{align: align, blk: blk});
    endtask

    // Tag-array model: valid bits are written on the negedge inside the tag-write cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (dwr_en) begin
                if (beat_q.size() == 0) check("dwr_unexpected", 32'(dwr_en), 32'd0);
                else begin
                    mon_b = beat_q.pop_front();
                    check("dwr_beat", 32'(dwr_beat), 32'(mon_b.beat));
                    check("dwr_align", 32'(dwr_align), 32'(mon_b.align));
                end
            end
            if (replace_tag || replace_tag_align) begin
                check("tag_exclusive", 32'(replace_tag & replace_tag_align), 32'd0);
                if (tag_q.size() == 0) check("tag_unexpected", 32'd1, 32'd0);
                else begin
                    mon_t = tag_q.pop_front();
                    check("tag_select", 32'(replace_tag_align), 32'(mon_t.align));
                    check("tag_valid", 32'(mon_t.align ? valid_in_align : valid_in), 32'd1);
                    check("tag_mem_addr", 32'(mem_addr), 32'(mon_t.blk));
                    res[mon_t.blk] = 1'b1;
                    upd_hits();
                end
            end
        end
    end

    // DRAM responder: back-to-back beats, or a fixed gap pattern.
    bit   gap_mode = 0;
    bit   force_rv = 0;
    logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   pi = 0;

    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (gap_mode) begin
                mem_rvalid = pat[pi % 7];
                pi++;
            end else mem_rvalid = 1'b1;
        end else mem_rvalid = force_rv;
    end

    task automatic drive(input logic [26:0] addr, input logic req, input logic mis);
        @(posedge clk);
        #1;
        cpu_req   = req;
        cpu_addr  = addr;
        missalign = mis;
        upd_hits();
    endtask

    // Counts stall cycles from the miss cycle until stall drops, bounded.
    task automatic run_miss(input string nm, input int exp_cycles);
        int n   = 0;
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1;
        end
        check({nm, "_stall_released"}, 32'(done), 32'd1);
        check({nm, "_stall_cycles"}, 32'(n), 32'(exp_cycles));
        check({nm, "_sb_drained"}, 32'(beat_q.size() + tag_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cpu_req = 1'b0;
        rst     = 1'b0;
        beat_q.delete();
        tag_q.delete();
        res.delete();
        upd_hits();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic req, mis, h, hm;
        logic exp_stall;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Held in reset the FSM stays in lookup, so stall is purely the combinational rule.
        mem_rvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cpu_req       = vecs[i].req;
            missalign     = vecs[i].mis;
            hit           = vecs[i].h;
            hit_missalign = vecs[i].hm;
            #3;
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_idle", i),
                  32'({mem_req, dwr_en, replace_tag, replace_tag_align, valid_in, valid_in_align}),
                  32'd0);
        end
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        do_reset();

        // Primary miss, back-to-back beats.
        expect_refill(1'b0, 21'h41);
        drive(27'h0001040, 1'b1, 1'b0);
        run_miss("primary", 6);

        // Resident block: no stall, no DRAM traffic.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hit_stall", 32'(stall), 32'd0);
            check("hit_mem_req", 32'(mem_req), 32'd0);
        end

        // Double miss: primary then aligned refill.
        do_reset();
        expect_refill(1'b0, 21'h41);
        expect_refill(1'b1, 21'h42);
        drive(27'h0001040, 1'b1, 1'b1);
        run_miss("double", 12);

        // Next-block address wraps from all-ones to zero.
        res[21'h1FFFFF] = 1'b1;
        expect_refill(1'b1, 21'h000000);
        drive(27'h7FFFFFE, 1'b1, 1'b1);
        run_miss("wrap", 6);

        // Beat gaps: 1,0,0,1,1,0,1 spans seven refill cycles.
        do_reset();
        pi       = 0;
        gap_mode = 1;
        expect_refill(1'b0, 21'h80);
        drive(27'h0002000, 1'b1, 1'b0);
        run_miss("gaps", 9);
        gap_mode = 0;

        // DRAM valid while idle is ignored.
        drive(27'h0002000, 1'b0, 1'b0);
        force_rv = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_rvalid_dwr_en", 32'(dwr_en), 32'd0);
        end
        force_rv = 0;

        // Asynchronous reset in the middle of a refill.
        expect_refill(1'b0, 21'hC0);
        drive(27'h0003000, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        beat_q.delete();
        tag_q.delete();
        res.delete();
        upd_hits();
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_dwr_en", 32'(dwr_en), 32'd0);
        check("midrst_stall", 32'(stall), 32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        force_rv = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_dwr_en", 32'(dwr_en), 32'd0);
            check("post_rst_mem_req", 32'(mem_req), 32'd0);
        end
        force_rv = 0;
        @(negedge clk);
        expect_refill(1'b0, 21'hC0);
        drive(27'h0003000, 1'b1, 1'b0);
        run_miss("after_rst", 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
